// File: rtl/imult_sched.sv
// imult_sched: round-robin arbiter that time-shares one iterative
// unsigned multiplier among NREQ requesters, with signed-operand support.
module imult_sched #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         sgn,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   output logic [NREQ-1:0]         ack,
   output logic [2*WIDTH-1:0]      res,
   output logic                    sched_busy,
   output logic                    mul_go,
   output logic [WIDTH-1:0]        mul_a,
   output logic [WIDTH-1:0]        mul_b,
   input  logic                    mul_busy,
   input  logic [2*WIDTH-1:0]      mul_p
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [IW-1:0]        rr_q, rr_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic                 neg_q, neg_d;
   logic                 started_q, started_d;
   logic [WIDTH-1:0]     mul_a_q, mul_a_d;
   logic [WIDTH-1:0]     mul_b_q, mul_b_d;
   logic                 mul_go_q, mul_go_d;
   logic [NREQ-1:0]      ack_q, ack_d;
   logic [2*WIDTH-1:0]   res_q, res_d;
   logic                 busy_q, busy_d;

   logic                 found;
   logic [IW-1:0]        win;
   logic [WIDTH-1:0]     a_sel, b_sel;
   logic                 a_neg, b_neg;

   // Round-robin pick: first pending request at or after the pointer.
   always_comb begin
      int j;
      j     = 0;
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(rr_q) + k) % NREQ;
         if (!found && req[j]) begin
            found = 1'b1;
            win   = IW'(j);
         end
      end
      a_sel = req_a[int'(win)*WIDTH +: WIDTH];
      b_sel = req_b[int'(win)*WIDTH +: WIDTH];
      a_neg = sgn[win] & a_sel[WIDTH-1];
      b_neg = sgn[win] & b_sel[WIDTH-1];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state: grant, launch, wait for multiplier, acknowledge.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (found) state_d = S_LAUNCH;
         S_LAUNCH: state_d = S_WAIT;
         S_WAIT:   if (started_q && !mul_busy) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output/datapath next values; every output leaves a flop.
   always_comb begin
      idx_d     = idx_q;
      neg_d     = neg_q;
      started_d = started_q;
      rr_d      = rr_q;
      mul_a_d   = mul_a_q;
      mul_b_d   = mul_b_q;
      mul_go_d  = 1'b0;
      ack_d     = '0;
      res_d     = res_q;
      busy_d    = (state_d != S_IDLE);
      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               idx_d    = win;
               mul_a_d  = a_neg ? -a_sel : a_sel;
               mul_b_d  = b_neg ? -b_sel : b_sel;
               neg_d    = a_neg ^ b_neg;
               mul_go_d = 1'b1;
            end
         end
         S_LAUNCH: started_d = 1'b0;
         S_WAIT: begin
            if (!started_q) started_d = 1'b1;
            else if (!mul_busy) res_d = neg_q ? -mul_p : mul_p;
         end
         S_DONE: begin
            ack_d[idx_q] = 1'b1;
            rr_d         = IW'((int'(idx_q) + 1) % NREQ);
         end
         default: ;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q     <= '0;
         neg_q     <= 1'b0;
         started_q <= 1'b0;
         rr_q      <= '0;
         mul_a_q   <= '0;
         mul_b_q   <= '0;
         mul_go_q  <= 1'b0;
         ack_q     <= '0;
         res_q     <= '0;
         busy_q    <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         neg_q     <= neg_d;
         started_q <= started_d;
         rr_q      <= rr_d;
         mul_a_q   <= mul_a_d;
         mul_b_q   <= mul_b_d;
         mul_go_q  <= mul_go_d;
         ack_q     <= ack_d;
         res_q     <= res_d;
         busy_q    <= busy_d;
      end
   end

   assign ack        = ack_q;
   assign res        = res_q;
   assign sched_busy = busy_q;
   assign mul_go     = mul_go_q;
   assign mul_a      = mul_a_q;
   assign mul_b      = mul_b_q;

endmodule

// File: tb/tb_imult_sched.sv
// tb_imult_sched: randomized scoreboard bench for imult_sched with a
// behavioural multiplier and a round-robin reference model.
module tb_imult_sched;

   localparam int WIDTH = 8;
   localparam int NREQ  = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req, sgn;
   logic [NREQ*WIDTH-1:0] req_a, req_b;
   logic [NREQ-1:0]       ack;
   logic [2*WIDTH-1:0]    res;
   logic                  sched_busy, mul_go;
   logic [WIDTH-1:0]      mul_a, mul_b;
   logic                  mul_busy;
   logic [2*WIDTH-1:0]    mul_p;

   imult_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk(clk), .rst(rst), .req(req), .sgn(sgn),
      .req_a(req_a), .req_b(req_b), .ack(ack), .res(res),
      .sched_busy(sched_busy), .mul_go(mul_go),
      .mul_a(mul_a), .mul_b(mul_b),
      .mul_busy(mul_busy), .mul_p(mul_p)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int mrr = 0;

   typedef struct { int idx; logic [2*WIDTH-1:0] res; } exp_t;
   typedef struct { int a; int b; } lch_t;
   exp_t exp_q[$];
   lch_t lch_q[$];

   logic [WIDTH-1:0] op_a[NREQ];
   logic [WIDTH-1:0] op_b[NREQ];
   logic             op_s[NREQ];

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural multiplier: busy for WIDTH cycles after go.
   logic               mbusy;
   int                 mcnt;
   logic [WIDTH-1:0]   ma, mb;
   logic [2*WIDTH-1:0] mp;
   assign mul_busy = mbusy;
   assign mul_p    = mp;
   always @(posedge clk) begin
      if (rst) begin
         mbusy <= 1'b0;
         mcnt  <= 0;
         mp    <= '0;
      end else if (mul_go) begin
         mbusy <= 1'b1;
         mcnt  <= WIDTH - 1;
         ma    <= mul_a;
         mb    <= mul_b;
      end else if (mbusy) begin
         if (mcnt == 0) begin
            mbusy <= 1'b0;
            mp    <= {{WIDTH{1'b0}}, ma} * {{WIDTH{1'b0}}, mb};
         end else begin
            mcnt <= mcnt - 1;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] want);
      n_cmp++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, want, $time);
      end
   endtask

   function automatic logic [2*WIDTH-1:0] ref_prod(
      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
      longint va, vb;
      logic [63:0] pu;
      va = s ? longint'($signed(a)) : longint'(a);
      vb = s ? longint'($signed(b)) : longint'(b);
      pu = 64'(va * vb);
      return pu[2*WIDTH-1:0];
   endfunction

   function automatic int mag(input logic [WIDTH-1:0] a, input logic s);
      if (s && a[WIDTH-1]) return (1 << WIDTH) - int'(a);
      return int'(a);
   endfunction

   // Predict n grants in round-robin order over the pending set.
   task automatic predict(input logic [NREQ-1:0] m, input int n,
                          input bit drop);
      logic [NREQ-1:0] pend;
      int w, j;
      exp_t e;
      lch_t l;
      pend = m;
      for (int g = 0; g < n; g++) begin
         w = -1;
         for (int k = 0; k < NREQ; k++) begin
            j = (mrr + k) % NREQ;
            if (w < 0 && pend[j]) w = j;
         end
         if (w < 0) break;
         e.idx = w;
         e.res = ref_prod(op_a[w], op_b[w], op_s[w]);
         l.a   = mag(op_a[w], op_s[w]);
         l.b   = mag(op_b[w], op_s[w]);
         exp_q.push_back(e);
         lch_q.push_back(l);
         mrr = (w + 1) % NREQ;
         if (drop) pend[w] = 1'b0;
      end
   endtask

   task automatic set_op(input int i, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic s);
      op_a[i] = a;
      op_b[i] = b;
      op_s[i] = s;
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
      sgn[i] = s;
   endtask

   task automatic rand_ops(input logic [NREQ-1:0] m);
      for (int i = 0; i < NREQ; i++)
         if (m[i])
            set_op(i, WIDTH'($urandom), WIDTH'($urandom),
                   1'($urandom_range(0, 1)));
   endtask

   // Raise requests m and collect n acks; hold keeps req up until the end.
   task automatic run(input logic [NREQ-1:0] m, input int n, input bit hold);
      int t0, got;
      bit first;
      @(posedge clk);
      #1;
      predict(m, n, !hold);
      req   = m;
      t0    = cyc + 1;
      got   = 0;
      first = 1'b1;
      for (int c = 0; c < (n + 1) * (WIDTH + 6) && got < n; c++) begin
         @(posedge clk);
         #1;
         if (ack != '0) begin
            got++;
            if (first) begin
               chk("latency", 64'(cyc - t0), 64'(WIDTH + 3));
               first = 1'b0;
            end
            if (!hold) req = req & ~ack;
            else if (got == n) req = '0;
         end
      end
      if (got < n) chk("acks_in_time", 64'(got), 64'(n));
      req = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("queue_drained", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
      lch_q.delete();
   endtask

   // Monitor: compare launches and acks against the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (mul_go) begin
            if (lch_q.size() == 0) begin
               chk("go_unexpected", 64'(mul_go), 64'(0));
            end else begin
               lch_t l;
               l = lch_q.pop_front();
               chk("mul_a", 64'(mul_a), 64'(l.a));
               chk("mul_b", 64'(mul_b), 64'(l.b));
               chk("go_while_busy", 64'(mul_busy), 64'(0));
            end
         end
         if (ack !== '0) begin
            if (exp_q.size() == 0) begin
               chk("ack_unexpected", 64'(ack), 64'(0));
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("ack", 64'(ack), 64'(1) << e.idx);
               chk("res", 64'(res), 64'(e.res));
            end
         end
      end
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ack"}, 64'(ack), 64'(0));
      chk({tag, "_res"}, 64'(res), 64'(0));
      chk({tag, "_busy"}, 64'(sched_busy), 64'(0));
      chk({tag, "_go"}, 64'(mul_go), 64'(0));
      chk({tag, "_mul_a"}, 64'(mul_a), 64'(0));
      chk({tag, "_mul_b"}, 64'(mul_b), 64'(0));
   endtask

   initial begin
      logic [NREQ-1:0] m;
      rst   = 1'b1;
      req   = '0;
      sgn   = '0;
      req_a = '0;
      req_b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      rst = 1'b0;
      mrr = 0;

      set_op(0, 8'd13, 8'd11, 1'b0);
      run(4'b0001, 1, 1'b0);
      set_op(1, 8'hFD, 8'd5, 1'b1);
      run(4'b0010, 1, 1'b0);
      set_op(2, 8'h80, 8'h80, 1'b1);
      run(4'b0100, 1, 1'b0);
      set_op(2, 8'h80, 8'h80, 1'b0);
      run(4'b0100, 1, 1'b0);

      rand_ops(4'b1111);
      run(4'b1111, 4, 1'b0);
      rand_ops(4'b0010);
      run(4'b0010, 1, 1'b0);
      rand_ops(4'b0011);
      run(4'b0011, 2, 1'b0);

      rand_ops(4'b0001);
      run(4'b0001, 1, 1'b0);
      rand_ops(4'b1001);
      run(4'b1001, 4, 1'b1);

      // Reset while waiting on the multiplier.
      @(posedge clk);
      #1;
      rand_ops(4'b0100);
      predict(4'b0100, 1, 1'b1);
      req = 4'b0100;
      repeat (5) @(posedge clk);
      #1;
      chk("busy_in_wait", 64'(sched_busy), 64'(1));
      rst = 1'b1;
      req = '0;
      @(posedge clk);
      #1;
      chk_reset_vals("abort");
      rst = 1'b0;
      exp_q.delete();
      lch_q.delete();
      mrr = 0;
      rand_ops(4'b0100);
      run(4'b0100, 1, 1'b0);

      repeat (25) begin
         m = NREQ'($urandom_range(1, 15));
         rand_ops(m);
         run(m, $countones(m), 1'b0);
      end
      repeat (3) begin
         m = NREQ'($urandom_range(1, 15));
         rand_ops(m);
         run(m, 6, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
